// File: rtl/spell_pkg.sv
// Shared constants for the spell-core SPI SRAM bridge.
// Holds the SPI command bytes, the FSM state encoding and the frame builder.
package spell_pkg;

    localparam logic [7:0] SPI_CMD_READ  = 8'h03;
    localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

    localparam int unsigned FRAME_BITS = 32;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SHIFT   = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    function automatic logic [31:0] spi_frame(input logic       wr,
                                              input logic [7:0] page,
                                              input logic [7:0] addr,
                                              input logic [7:0] data);
        return {(wr ? SPI_CMD_WRITE : SPI_CMD_READ), page, addr, data};
    endfunction

endpackage

// File: rtl/spell_spi_shifter.sv
// 32-bit SPI mode-0 frame shifter with SCK divider.
// Shifts MSB first on SCK falling phases and samples MISO as SCK rises.
module spell_spi_shifter
    import spell_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] frame,
    input  logic        miso,
    output logic        sck,
    output logic        mosi,
    output logic [7:0]  rx,
    output logic        done
);

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [5:0] BIT_LAST = 6'(FRAME_BITS - 1);

    logic [3:0]  div_q, div_d;
    logic [5:0]  bit_q, bit_d;
    logic        sck_q, sck_d;
    logic        active_q, active_d;
    logic [31:0] sh_q, sh_d;
    logic [7:0]  rx_q, rx_d;

    always_comb begin
        div_d    = div_q;
        bit_d    = bit_q;
        sck_d    = sck_q;
        active_d = active_q;
        sh_d     = sh_q;
        rx_d     = rx_q;
        done     = 1'b0;
        if (load) begin
            div_d    = '0;
            bit_d    = '0;
            sck_d    = 1'b0;
            active_d = 1'b1;
            sh_d     = frame;
        end else if (active_q) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                if (!sck_q) begin
                    sck_d = 1'b1;
                    rx_d  = {rx_q[6:0], miso};
                end else begin
                    // MOSI only moves here, at the start of a low phase
                    sck_d = 1'b0;
                    sh_d  = {sh_q[30:0], 1'b0};
                    bit_d = bit_q + 6'd1;
                    if (bit_q == BIT_LAST) begin
                        active_d = 1'b0;
                        done     = 1'b1;
                        sh_d     = '0;
                    end
                end
            end else begin
                div_d = div_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= '0;
            bit_q    <= '0;
            sck_q    <= 1'b0;
            active_q <= 1'b0;
            sh_q     <= '0;
            rx_q     <= '0;
        end else begin
            div_q    <= div_d;
            bit_q    <= bit_d;
            sck_q    <= sck_d;
            active_q <= active_d;
            sh_q     <= sh_d;
            rx_q     <= rx_d;
        end
    end

    assign sck  = sck_q;
    assign mosi = sh_q[31];
    assign rx   = rx_q;

endmodule

// File: rtl/spell_spi_mem.sv
// Spell-core memory request to SPI SRAM bridge: one byte read or write per request.
// The request is captured into the shifter's frame register on accept.
module spell_spi_mem
    import spell_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 2,
    parameter logic [7:0]  DATA_PAGE = 8'h01
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       select,
    input  logic [7:0] addr,
    input  logic [7:0] data_in,
    input  logic       memory_type_data,
    input  logic       write,
    output logic [7:0] data_out,
    output logic       data_ready,
    output logic       spi_cs_n,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    logic [1:0] state_q, state_d;
    logic       cs_n_q, cs_n_d;
    logic       write_q, write_d;
    logic [7:0] data_out_q, data_out_d;
    logic [3:0] gap_q, gap_d;

    logic        shift_load;
    logic        shift_done;
    logic [7:0]  shift_rx;
    logic [31:0] shift_frame;

    assign shift_frame = spi_frame(write, (memory_type_data ? DATA_PAGE : 8'h00),
                                   addr, data_in);

    always_comb begin
        state_d    = state_q;
        cs_n_d     = cs_n_q;
        write_d    = write_q;
        data_out_d = data_out_q;
        gap_d      = gap_q;
        shift_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (select) begin
                    shift_load = 1'b1;
                    write_d    = write;
                    cs_n_d     = 1'b0;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (shift_done) begin
                    cs_n_d = 1'b1;
                    if (!write_q) data_out_d = shift_rx;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                gap_d   = '0;
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                // Keeps chip select high for at least CLK_DIV cycles between frames
                if (gap_q != DIV_LAST) gap_d = gap_q + 4'd1;
                if (!select && gap_q == DIV_LAST) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cs_n_q     <= 1'b1;
            write_q    <= 1'b0;
            data_out_q <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            cs_n_q     <= cs_n_d;
            write_q    <= write_d;
            data_out_q <= data_out_d;
            gap_q      <= gap_d;
        end
    end

    spell_spi_shifter #(
        .CLK_DIV(CLK_DIV)
    ) u_shifter (
        .clk  (clk),
        .rst_n(rst_n),
        .load (shift_load),
        .frame(shift_frame),
        .miso (spi_miso),
        .sck  (spi_sck),
        .mosi (spi_mosi),
        .rx   (shift_rx),
        .done (shift_done)
    );

    assign data_out   = data_out_q;
    assign data_ready = (state_q == ST_DONE);
    assign spi_cs_n   = cs_n_q;

endmodule

// File: tb/tb_spell_spi_mem.sv
// Bench for spell_spi_mem: CLK_DIV=2 and CLK_DIV=1 instances, each with an SPI SRAM model.
// Table of transactions plus a mid-frame reset sequence; expectations go through a scoreboard.
module tb_spell_spi_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       sel   [2];
    logic [7:0] addr  [2];
    logic [7:0] din   [2];
    logic       typ   [2];
    logic       wr    [2];
    logic [7:0] dout  [2];
    logic       rdy   [2];
    logic       cs    [2];
    logic       sck   [2];
    logic       mosi  [2];
    logic       miso  [2];
    logic [7:0] rbyte [2];

    int errors = 0;
    int checks = 0;
    int run  [2];
    bit seen [2];

    for (genvar g = 0; g < 2; g++) begin : u
        spell_spi_mem #(
            .CLK_DIV  ((g == 0) ? 2 : 1),
            .DATA_PAGE(8'h01)
        ) dut (
            .clk             (clk),
            .rst_n           (rst_n),
            .select          (sel[g]),
            .addr            (addr[g]),
            .data_in         (din[g]),
            .memory_type_data(typ[g]),
            .write           (wr[g]),
            .data_out        (dout[g]),
            .data_ready      (rdy[g]),
            .spi_cs_n        (cs[g]),
            .spi_sck         (sck[g]),
            .spi_mosi        (mosi[g]),
            .spi_miso        (miso[g])
        );

        // SRAM model: captures MOSI on SCK rise, drives read byte on SCK fall
        logic [31:0] mosi_sh = '0;
        int          bits    = 0;

        always @(posedge sck[g] or negedge cs[g]) begin
            if (sck[g]) begin
                mosi_sh <= {mosi_sh[30:0], mosi[g]};
                bits    <= bits + 1;
            end else begin
                bits <= 0;
            end
        end

        always @(negedge sck[g] or negedge cs[g]) begin
            if (bits >= 24 && bits < 32) miso[g] <= rbyte[g][3'(31 - bits)];
            else                         miso[g] <= 1'b0;
        end
    end

    typedef struct {
        int         g;
        logic       typ;
        logic       wr;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] rb;
        logic [7:0] exp_dout;
        int         lat;
        int         hold;
        bit         glitch;
    } vec_t;

    typedef struct {
        logic [31:0] frame;
        logic [7:0]  dout;
        int          lat;
        logic        wr;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (cs[k] === 1'b1) begin
                run[k]++;
            end else begin
                if (seen[k] && run[k] > 0) begin
                    checks++;
                    if (run[k] < ((k == 0) ? 2 : 1)) begin
                        errors++;
                        $display("FAIL cs_gap inst%0d: high %0d cycles, need >= %0d",
                                 k, run[k], (k == 0) ? 2 : 1);
                    end
                end
                seen[k] = 1'b1;
                run[k]  = 0;
            end
        end
    endtask

    task automatic txn(input vec_t v);
        exp_t        e;
        int          cnt;
        bit          got;
        bit          ok;
        logic [31:0] fr;
        sel[v.g] = 1'b0;
        repeat (4) tick();
        addr[v.g]  = v.a;
        din[v.g]   = v.d;
        typ[v.g]   = v.typ;
        wr[v.g]    = v.wr;
        rbyte[v.g] = v.rb;
        e.frame = {(v.wr ? 8'h02 : 8'h03), (v.typ ? 8'h01 : 8'h00), v.a, v.d};
        e.dout  = v.exp_dout;
        e.lat   = v.lat;
        e.wr    = v.wr;
        sb.push_back(e);
        sel[v.g] = 1'b1;
        cnt = 0;
        got = 1'b0;
        while (!got && cnt < 300) begin
            tick();
            cnt++;
            if (v.glitch && cnt == 10) begin
                addr[v.g] = ~v.a;
                din[v.g]  = ~v.d;
                typ[v.g]  = ~v.typ;
                wr[v.g]   = ~v.wr;
                sel[v.g]  = 1'b0;
            end
            if (rdy[v.g] === 1'b1) got = 1'b1;
        end
        e = sb.pop_front();
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout inst%0d: no data_ready within %0d cycles, need %0d",
                     v.g, cnt, e.lat);
        end else begin
            chk("ready_latency", cnt, e.lat);
            fr = (v.g == 0) ? u[0].mosi_sh : u[1].mosi_sh;
            if (e.wr) chk("mosi_frame", fr, e.frame);
            else      chk("mosi_frame_hdr", {8'h00, fr[31:8]}, {8'h00, e.frame[31:8]});
            chk("data_out", dout[v.g], e.dout);
            tick();
            chk("ready_one_cycle", rdy[v.g], 1'b0);
            ok = 1'b1;
            for (int i = 0; i < v.hold; i++) begin
                if (cs[v.g] !== 1'b1 || sck[v.g] !== 1'b0 || rdy[v.g] !== 1'b0) ok = 1'b0;
                tick();
            end
            if (v.hold > 0) chk("held_select_idle", ok, 1'b1);
        end
        sel[v.g] = 1'b0;
    endtask

    task automatic reset_mid_frame();
        int cnt;
        sel[0] = 1'b0;
        repeat (4) tick();
        addr[0] = 8'h77;
        din[0]  = 8'h00;
        typ[0]  = 1'b0;
        wr[0]   = 1'b0;
        rbyte[0] = 8'hEE;
        sel[0]  = 1'b1;
        cnt = 0;
        while (u[0].bits < 17 && cnt < 300) begin
            tick();
            cnt++;
        end
        if (cnt >= 300) begin
            checks++;
            errors++;
            $display("FAIL reset_bit17_timeout: bits=%0d after %0d cycles, need 17", u[0].bits, cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("mid_reset_cs_n", cs[0], 1'b1);
        chk("mid_reset_sck", sck[0], 1'b0);
        chk("mid_reset_mosi", mosi[0], 1'b0);
        chk("mid_reset_data_out", dout[0], 8'h00);
        sel[0] = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            sel[k]   = 1'b0;
            addr[k]  = '0;
            din[k]   = '0;
            typ[k]   = 1'b0;
            wr[k]    = 1'b0;
            rbyte[k] = '0;
            run[k]   = 0;
            seen[k]  = 1'b0;
        end

        //          g  typ   wr    addr   din    miso   dout   lat  hold glitch
        tbl[0] = '{0, 1'b0, 1'b0, 8'h12, 8'h00, 8'hA5, 8'hA5, 129, 0,  1'b0};
        tbl[1] = '{0, 1'b1, 1'b1, 8'h34, 8'h5C, 8'h00, 8'hA5, 129, 20, 1'b0};
        tbl[2] = '{0, 1'b1, 1'b0, 8'h80, 8'hFF, 8'h3C, 8'h3C, 129, 0,  1'b1};
        tbl[3] = '{0, 1'b0, 1'b0, 8'h55, 8'h00, 8'hC3, 8'hC3, 129, 0,  1'b0};
        tbl[4] = '{1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h81, 8'h81, 65,  0,  1'b0};
        tbl[5] = '{1, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h7E, 8'h7E, 65,  0,  1'b0};
        tbl[6] = '{1, 1'b1, 1'b1, 8'hFF, 8'hA0, 8'h99, 8'h7E, 65,  5,  1'b0};

        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_cs_n", cs[k], 1'b1);
            chk("reset_sck", sck[k], 1'b0);
            chk("reset_mosi", mosi[k], 1'b0);
            chk("reset_data_ready", rdy[k], 1'b0);
            chk("reset_data_out", dout[k], 8'h00);
        end
        rst_n = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 3; i++) txn(tbl[i]);
        reset_mid_frame();
        for (int i = 3; i < 7; i++) txn(tbl[i]);

        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
